divider64b_seq: RTL and testbench
=================================

DIVIDER64B_SEQ -- requirements
Module: divider64b_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; only 64 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port START  input  1  request; sampled only while BUSY=0.
REQ-005 SHALL have port SIGNED  input  1  1 = two's-complement DIV/REM, 0 = unsigned DIVU/REMU; latched with START.
REQ-006 SHALL have port A  input  64  dividend; latched with START.
REQ-007 SHALL have port B  input  64  divisor; latched with START.
REQ-008 SHALL have port BUSY  output  1  operation in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-010 SHALL have port Q  output  64  quotient, registered.
REQ-011 SHALL have port R  output  64  remainder, registered.
REQ-012 SHALL have port DIV0  output  1  registered flag: last completed operation had B=0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FINISH.
REQ-014 SHALL, in IDLE with START=1 at edge E0, latch A, B, SIGNED, enter RUN, and drive BUSY=1 from E0.
REQ-015 SHALL ignore START while BUSY=1; latched operands are not disturbed.
REQ-016 SHALL, in RUN, perform restoring division: one quotient bit per cycle, MSB first, 64 iterations on edges E1..E64, via a 65-bit trial subtraction of the divisor from the partial remainder.
REQ-017 SHALL divide magnitudes in signed mode: |A|, |B| taken at latch time; Q negated if sign(A) xor sign(B); R negated if sign(A).
REQ-018 SHALL, at E65 (FINISH), load Q, R, DIV0, drive DONE=1 for exactly the cycle after E65, drop BUSY, and return to IDLE.
REQ-019 SHALL handle B=0 without iterating: at E1, Q=all ones, R=A, DIV0=1, DONE=1 for one cycle, BUSY=0; applies to both modes.
REQ-020 SHALL handle signed overflow (SIGNED=1, A=0x8000_0000_0000_0000, B=all ones) without iterating: at E1, Q=A, R=0, DIV0=0, DONE one cycle.
REQ-021 SHALL hold Q, R and DIV0 stable from completion until the next completion or reset.
REQ-022 SHALL allow a new START in the cycle DONE is high (BUSY=0 then); that START begins a new operation at the same edge.
REQ-023 SHALL ensure results satisfy A = Q*B + R (mod 2^64), with |R| < |B| for B!=0.

Reset
REQ-024 SHALL, when reset=1 at an edge, force state IDLE, BUSY=0, DONE=0, Q=0, R=0, DIV0=0, and clear internal registers.
REQ-025 SHALL give reset priority over START and over any in-flight operation; an aborted operation produces no DONE.

Verification
REQ-026 Unsigned: SIGNED=0, A=100, B=7, START -> DONE 66 cycles after START, Q=14, R=2, DIV0=0.
REQ-027 Signed: SIGNED=1, A=-7, B=2 -> Q=0xFFFF_FFFF_FFFF_FFFD (-3), R=0xFFFF_FFFF_FFFF_FFFF (-1).
REQ-028 Divide by zero: A=5, B=0 -> DONE one cycle after START edge, Q=0xFFFF_FFFF_FFFF_FFFF, R=5, DIV0=1.
REQ-029 Overflow: SIGNED=1, A=0x8000_0000_0000_0000, B=-1 -> fast DONE, Q=0x8000_0000_0000_0000, R=0.
REQ-030 Busy/reset: START (A=1000, B=3), second START (A=9, B=9) at cycle 10 -> ignored, Q=333, R=1; repeat with reset at cycle 30 -> BUSY=0 next cycle, no DONE, Q=R=0.
REQ-031 Back-to-back: START asserted in DONE cycle with A=0xFFFF_FFFF_FFFF_FFFF, B=1, SIGNED=0 -> second DONE 66 cycles later, Q=A, R=0.

Source files
------------

// File: rtl/divider64b_seq.sv
// Sequential restoring divider, one quotient bit per clock, DIV/DIVU/REM/REMU.
// Ports: clk, reset (sync, active-high), START/SIGNED/A/B request,
//        BUSY/DONE status, Q/R registered results, DIV0 divide-by-zero flag.
module divider64b_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DIV0
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_raw;
    logic             neg_q;
    logic             neg_r;
    logic             div0_c;
    logic             ovf_c;

    logic [WIDTH:0]   partial;
    logic [WIDTH+1:0] diff;
    logic             fit;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Shift the next dividend bit (MSB of quo) into the partial remainder
    // and try to subtract the divisor; a non-negative result means q bit = 1.
    always_comb begin
        partial = {rem, quo[WIDTH-1]};
        diff    = {1'b0, partial} - {2'b00, dvs};
        fit     = ~diff[WIDTH+1];
        abs_a   = (SIGNED && A[WIDTH-1]) ? -A : A;
        abs_b   = (SIGNED && B[WIDTH-1]) ? -B : B;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            a_raw  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0_c <= 1'b0;
            ovf_c  <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            Q      <= '0;
            R      <= '0;
            DIV0   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        a_raw  <= A;
                        quo    <= abs_a;
                        dvs    <= abs_b;
                        rem    <= '0;
                        cnt    <= '0;
                        neg_q  <= SIGNED && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r  <= SIGNED && A[WIDTH-1];
                        div0_c <= (B == '0);
                        ovf_c  <= SIGNED && (A == MIN_NEG) && (B == '1);
                        BUSY   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Special cases are resolved on the first RUN edge.
                    if (div0_c) begin
                        Q     <= '1;
                        R     <= a_raw;
                        DIV0  <= 1'b1;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else if (ovf_c) begin
                        Q     <= a_raw;
                        R     <= '0;
                        DIV0  <= 1'b0;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rem <= fit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], fit};
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    Q     <= neg_q ? -quo : quo;
                    R     <= neg_r ? -rem : rem;
                    DIV0  <= 1'b0;
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider64b_seq.sv
// Randomized self-checking bench for divider64b_seq against an
// arithmetic reference model (/ and % with the RISC-V special cases).
module tb_divider64b_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] q;
    logic [63:0] r;
    logic        div0;

    int total = 0;
    int passed = 0;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    divider64b_seq #(.WIDTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .START (start),
        .SIGNED(sgn),
        .A     (a),
        .B     (b),
        .BUSY  (busy),
        .DONE  (done),
        .Q     (q),
        .R     (r),
        .DIV0  (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            passed++;
    endtask

    function automatic void ref_div(input logic s, input logic [63:0] x,
                                    input logic [63:0] y,
                                    output logic [63:0] eq,
                                    output logic [63:0] er,
                                    output logic ed, output int lat);
        ed  = 1'b0;
        lat = 1;
        if (y == 0) begin
            eq = ONES;
            er = x;
            ed = 1'b1;
        end else if (s && x == MINV && y == ONES) begin
            eq = x;
            er = 0;
        end else if (s) begin
            eq  = $signed(x) / $signed(y);
            er  = $signed(x) % $signed(y);
            lat = 65;
        end else begin
            eq  = x / y;
            er  = x % y;
            lat = 65;
        end
    endfunction

    // Drives a request now; returns just after the sampling edge.
    task automatic launch(input logic s, input logic [63:0] x,
                          input logic [63:0] y);
        start = 1'b1;
        sgn   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 200);
    endtask

    task automatic run_op(input string tag, input logic s,
                          input logic [63:0] x, input logic [63:0] y);
        logic [63:0] eq, er;
        logic        ed;
        int          lat, n;
        ref_div(s, x, y, eq, er, ed, lat);
        @(negedge clk);
        launch(s, x, y);
        wait_done(n);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_div0"}, {63'd0, div0}, {63'd0, ed});
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_hold_q"}, q, eq);
    endtask

    initial begin
        int n, dcount;
        logic [63:0] x, y;
        logic s;
        reset = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_q", q, 64'd0);
        check("rst_r", r, 64'd0);
        check("rst_div0", {63'd0, div0}, 64'd0);
        reset = 1'b0;

        run_op("udiv", 1'b0, 64'd100, 64'd7);
        run_op("sdiv", 1'b1, -64'sd7, 64'd2);
        run_op("div0", 1'b0, 64'd5, 64'd0);
        run_op("sdiv0", 1'b1, -64'sd5, 64'd0);
        run_op("ovf", 1'b1, MINV, ONES);
        run_op("uminv", 1'b0, MINV, ONES);
        run_op("max1", 1'b0, ONES, 64'd1);

        // START while busy must be ignored.
        @(negedge clk);
        launch(1'b0, 64'd1000, 64'd3);
        repeat (9) @(negedge clk);
        start = 1'b1;
        a     = 64'd9;
        b     = 64'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("ign_q", q, 64'd333);
        check("ign_r", r, 64'd1);

        // Reset aborts an in-flight operation without DONE.
        @(negedge clk);
        launch(1'b0, 64'd1000, 64'd3);
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_q", q, 64'd0);
        check("abort_r", r, 64'd0);
        dcount = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("abort_nodone", 64'(dcount), 64'd0);

        // Back-to-back: new START during the DONE cycle.
        @(negedge clk);
        launch(1'b0, 64'd100, 64'd7);
        wait_done(n);
        check("b2b_first_q", q, 64'd14);
        launch(1'b0, ONES, 64'd1);
        wait_done(n);
        check("b2b_lat", 64'(n), 64'd65);
        check("b2b_q", q, ONES);
        check("b2b_r", r, 64'd0);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            x = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: y = 64'd0;
                1: y = 64'($urandom_range(1, 50));
                2: begin
                    s = 1'b1;
                    x = MINV;
                    y = ONES;
                end
                3: y = {32'd0, $urandom};
                default: y = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 3) == 0)
                x = 64'($urandom_range(0, 1000));
            run_op("rnd", s, x, y);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
